// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared types and constants for the fetch queue unit
package fetch_queue_unit_pkg;

  localparam int ILEN     = 32;
  localparam int PC_INC   = 4;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

  function automatic int entry_width(input int xlen);
    return xlen + ILEN;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - memory, redirect and decode-side signals of the fetch queue unit
interface fetch_queue_unit_if
  import fetch_queue_unit_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            fetch_fault;
  logic            halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault, halted,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault, halted,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_queue_unit_fetch_fifo.sv
// rtl/fetch_queue_unit_fetch_fifo.sv - fetch entry FIFO with registered head and synchronous flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o,
  output logic             head_valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push      = push_i && !flush_i && (count_q != CW'(DEPTH));
    do_pop       = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d     = wr_ptr_q + AW'(do_push);
    rd_ptr_d     = rd_ptr_q + AW'(do_pop);
    count_d      = count_q + CW'(do_push) - CW'(do_pop);
    head_d       = head_q;
    head_valid_d = (count_d != '0);
    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else if (count_d != '0) begin
      // The entry written this cycle becomes the head when it lands on the new read pointer.
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o      = count_q;
  assign head_o       = head_q;
  assign head_valid_o = head_valid_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC owner, single-outstanding imem requester and decode-side fetch queue
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  fetch_queue_unit_if.master  bus
);

  localparam int EW = entry_width(XLEN);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            halt_pend_q, halt_pend_d;
  logic            fault_q, fault_d;

  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            head_valid;
  logic            redirect, misaligned, outstanding;
  logic            issue, push, pop;

  always_comb begin
    redirect    = bus.redirect_valid;
    misaligned  = redirect && (bus.redirect_pc[1:0] != 2'b00);
    outstanding = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !bus.imem_rvalid;
    // One slot is kept free for the response before a request goes out.
    issue       = !rst && (state_q == S_IDLE) && !redirect && (count < CW'(DEPTH));
    push        = (state_q == S_WAIT) && bus.imem_rvalid && !redirect;
    pop         = head_valid && bus.instr_ready && !redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      halt_pend_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      halt_pend_q <= halt_pend_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    if (redirect) begin
      // A response still in flight must be swallowed in DRAIN before halting or refetching.
      halt_pend_d = misaligned && outstanding;
      if (outstanding) begin
        state_d = S_DRAIN;
      end else begin
        state_d = misaligned ? S_HALT : S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE:  if (issue) state_d = S_WAIT;
        S_WAIT:  if (bus.imem_rvalid) state_d = S_IDLE;
        S_DRAIN: if (bus.imem_rvalid) begin
                   state_d     = halt_pend_q ? S_HALT : S_IDLE;
                   halt_pend_d = 1'b0;
                 end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    fault_d  = misaligned;
    if (redirect) begin
      pc_d = bus.redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + XLEN'(PC_INC);
      req_pc_d = pc_q;
    end
  end

  always_comb begin
    bus.imem_req    = issue;
    bus.imem_addr   = pc_q;
    bus.instr_valid = head_valid;
    bus.instr       = head[ILEN-1:0];
    bus.instr_pc    = head[EW-1:ILEN];
    bus.fetch_fault = fault_q;
    bus.halted      = (state_q == S_HALT);
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_data_i  ({req_pc_q, bus.imem_rdata}),
    .pop_i        (pop),
    .flush_i      (redirect),
    .count_o      (count),
    .head_o       (head),
    .head_valid_o (head_valid)
  );

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end that replaces the single-cycle PC register, PC-next logic and combinational instruction read.
- Owns the PC and issues one-at-a-time requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO toward decode.
- Accepts redirects (taken branch/jump) from execute: flushes the FIFO and discards any in-flight response.

Parameters:
- XLEN, 32, address/instruction-bus width; instructions are always 32 bits, PC is XLEN bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request valid for one cycle per fetch
- imem_addr  out  XLEN  word-aligned fetch address
- imem_rvalid  in  1  response strobe
- imem_rdata  in  32  response instruction
- redirect_valid  in  1  one-cycle redirect from execute
- redirect_pc  in  XLEN  redirect target
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  XLEN  head PC
- fetch_fault  out  1  one-cycle pulse on misaligned redirect target

Behaviour:
- Reset values: PC=RESET_PC, FSM=IDLE, FIFO empty, count=0.
  - Outputs at reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0, halted=0.
- FSM states: IDLE, WAIT, DRAIN, HALT.
  - IDLE -> WAIT: issue when count + 1 <= DEPTH (a free slot is reserved for the response) and no redirect this cycle. Drive imem_req=1, imem_addr=PC; on the next edge PC=PC+4 (wraps modulo 2^XLEN).
  - WAIT -> IDLE on imem_rvalid: push {PC_of_request, imem_rdata}. The request PC is held in a register.
  - WAIT + redirect_valid -> DRAIN: the response will be discarded.
  - DRAIN -> IDLE on imem_rvalid: no push.
  - DRAIN: a further redirect updates the PC only.
  - HALT: no requests. Left only via an aligned redirect, to IDLE.
- Redirect in any state:
  - FIFO cleared (count=0, pointers reset) on that edge.
  - PC=redirect_pc.
  - Takes priority over a same-cycle pop, push, or issue. No imem_req in the redirect cycle.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - fetch_fault=1 next cycle, for one cycle.
  - FIFO flushed, FSM -> HALT, or -> DRAIN if a response is outstanding, then HALT.
- Redirect with imem_rvalid in the same cycle in WAIT: the response is discarded and the FSM goes to IDLE directly.
- FIFO behaviour:
  - Pop when instr_valid && instr_ready. Push and pop may occur in the same cycle; count is unchanged.
  - instr, instr_pc and instr_valid are registered from the head. First-word latency: issue at cycle N, rvalid at N+k, instr_valid at N+k+1.
  - Full: no new issue. An accepted response never overflows because the slot was reserved.
  - Empty: instr_valid=0; instr and instr_pc hold their last values.
- Throughput: at most one request outstanding. Back-to-back issue occurs in the cycle after rvalid (IDLE re-entry).
- Reset asserted mid-operation: immediate return to reset values. Any later imem_rvalid arriving in IDLE is ignored.
- Any imem_rvalid in IDLE or HALT is ignored.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, WAIT, DRAIN, HALT),
  - the instruction width constant ILEN=32,
  - the PC increment constant 4,
  - the fetch-entry struct {pc, instr}.
- One sub-module: fetch_fifo.
  - Parametrised by DEPTH and entry width.
  - Ports: push, pop, flush, count, head.
  - Synchronous flush, asynchronous active-high reset.

Test Plan:
- Reset, then memory returns 0x00000013 with latency 1 and instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_pc follows 0x0,0x4,0x8 with instr_valid one cycle after each rvalid.
- instr_ready=0, latency 1, DEPTH=4 -> exactly 4 pushes, no fifth imem_req. Raising instr_ready for one cycle -> exactly one new request.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later with 0xDEADBEEF -> response discarded, FIFO empty, next imem_addr=0x100, first instr_pc=0x100.
- Redirect to 0x200 in the same cycle as imem_rvalid and a decode pop -> nothing pushed, count=0, next imem_addr=0x200.
- Redirect to 0x102 -> fetch_fault pulses once, no imem_req for 10 cycles. Redirect to 0x300 -> fetching resumes at 0x300.
- PC=0xFFFFFFFC with XLEN=32 -> next imem_addr=0x00000000. Asserting rst while in WAIT -> all outputs return to reset values, and a stale rvalid one cycle later produces no instr_valid.
